unified_mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the pipelined CPU's instruction-fetch port and its MEM-stage data port. It grants at most one request per cycle. Data accesses have priority; a starvation counter forces a fetch grant after a bounded run of data grants. An in-flight tag pipeline routes each read response back to its requester. The CPU uses the `*_gnt` outputs as stall conditions: fetch holds PC on `!i_gnt`, and MEM holds on `!d_gnt`.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/unified_mem_arbiter_resp_tag_pipe.sv | 39 +++
 rtl/unified_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the unified memory arbiter: requester owner
//               encoding, arbitration FSM states and the response tag.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Which requester a memory access belongs to
  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_e;

  // Arbitration priority state
  typedef enum logic {
    DPRI = 1'b0,
    IPRI = 1'b1
  } arb_state_e;

  // One in-flight read slot
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  // Deepest supported memory read latency
  localparam int MEM_LAT_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_resp_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : resp_tag_pipe
// Description : Fixed-depth shift register of response tags. A tag entering
//               stage 0 leaves the last stage DEPTH cycles later, lining up
//               with the memory read data. Reset clears every stage at once.
// Revision    : 1.0 - initial release
// ============================================================================
module resp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t tag_q [DEPTH];

  // Shift tags one stage per cycle; asynchronous clear drops all in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= tag_i;
      for (int s = 1; s < DEPTH; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tag_o = tag_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unified_mem_arbiter
// Description : Shares one single-port synchronous memory between the CPU
//               fetch port and the MEM-stage data port. Data has priority;
//               a starvation counter forces a fetch grant after STARVE_MAX
//               consecutive data grants against a waiting fetch. A tag pipe
//               routes each read response back to its requester.
// Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_we,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_we,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [0:0] ST_DPRI    = 1'(DPRI);
  localparam logic [0:0] ST_IPRI    = 1'(IPRI);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
    $error("unified_mem_arbiter: MEM_LAT out of range");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("unified_mem_arbiter: STARVE_MAX out of range");
  end

  logic [0:0] state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic       gnt_i, gnt_d;
  tag_t       tag_in, tag_out;

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      if (state_q == ST_IPRI) begin
        if (i_req)      gnt_i = 1'b1;
        else if (d_req) gnt_d = 1'b1;
      end else begin
        if (d_req)      gnt_d = 1'b1;
        else if (i_req) gnt_i = 1'b1;
      end
    end
  end

  assign i_gnt = gnt_i;
  assign d_gnt = gnt_d;

  // Starvation count and priority next-state; the DPRI->IPRI decision looks at
  // the value the counter takes at this edge so fetch wins on the next cycle
  always_comb begin
    scnt_d  = scnt_q;
    state_d = state_q;
    if (gnt_i || !i_req) begin
      scnt_d = 4'd0;
    end else if (gnt_d) begin
      scnt_d = (scnt_q == 4'hF) ? scnt_q : scnt_q + 4'd1;
    end
    if (state_q == ST_DPRI) begin
      if (scnt_d == STARVE_LIM) state_d = ST_IPRI;
    end else begin
      if (gnt_i || !i_req) state_d = ST_DPRI;
    end
  end

  // Priority state and starvation counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_DPRI;
      scnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
    end
  end

  // Memory strobe and operand mux; idle cycles drive zeros
  always_comb begin
    m_req   = gnt_i | gnt_d;
    m_addr  = '0;
    m_wdata = '0;
    m_we    = 4'b0000;
    if (gnt_d) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_we    = d_we;
    end else if (gnt_i) begin
      m_addr  = i_addr;
    end
  end

  // Reads launch a valid tag; stores launch an empty slot
  always_comb begin
    tag_in.valid = gnt_i | (gnt_d & (d_we == 4'b0000));
    tag_in.owner = gnt_i ? FETCH : DATA;
  end

  resp_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign i_rvalid = tag_out.valid && (tag_out.owner == FETCH);
  assign d_rvalid = tag_out.valid && (tag_out.owner == DATA);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unified_mem_arbiter
// Description : Directed self-checking bench for unified_mem_arbiter. One
//               instance with MEM_LAT=1 backed by a small memory model, and
//               one with MEM_LAT=3 for latency and mid-flight reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic clk;
  logic reset, reset3;
  int   checks   = 0;
  int   failures = 0;

  // MEM_LAT=1 instance signals
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_we;

  // MEM_LAT=3 instance signals
  logic        i_req3;
  logic [31:0] i_addr3;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, m_req3;
  logic [31:0] i_rdata3, d_rdata3, m_addr3, m_wdata3;
  logic [3:0]  m_we3;
  logic [31:0] m_rdata3;
  logic        zero1;
  logic [31:0] zero32;
  logic [3:0]  zero4;

  assign m_rdata3 = 32'h0;
  assign zero1    = 1'b0;
  assign zero32   = 32'h0;
  assign zero4    = 4'h0;

  logic [31:0] mem [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset3),
    .i_req(i_req3), .i_addr(i_addr3), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(zero1), .d_addr(zero32), .d_wdata(zero32), .d_we(zero4), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_req(m_req3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_we(m_we3), .m_rdata(m_rdata3)
  );

  // Single-port memory, one-cycle read latency; word k initialised to A0000000+k
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + 32'(k);
      m_rdata <= 32'h0;
    end else if (m_req) begin
      if (m_we == 4'b0000) begin
        m_rdata <= mem[m_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    d_req = 1'b1; d_addr = 32'h0000_0020; d_we = 4'b0000; d_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({i_gnt, d_gnt, m_req} !== 3'b000) begin failures++;
      $display("FAIL reset_gnt: got i_gnt/d_gnt/m_req=%b expected 000", {i_gnt, d_gnt, m_req}); end
    checks++; if ({m_addr, m_wdata, m_we} !== 68'h0) begin failures++;
      $display("FAIL reset_mbus: got addr=%h wdata=%h we=%b expected all 0", m_addr, m_wdata, m_we); end
    checks++; if ({i_rvalid, d_rvalid} !== 2'b00) begin failures++;
      $display("FAIL reset_rvalid: got %b expected 00", {i_rvalid, d_rvalid}); end
    cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({d_gnt, i_gnt} !== 2'b10 || m_addr !== 32'h20) begin failures++;
      $display("FAIL reset_first_grant: got d_gnt=%b i_gnt=%b m_addr=%h expected 1 0 20", d_gnt, i_gnt, m_addr); end
    cycle();
    i_req = 1'b0; d_req = 1'b0;
    cycle();
  endtask

  task automatic test_fetch_only();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'hA000_0040;
    exp_data[1] = 32'hA000_0041;
    exp_data[2] = 32'hA000_0042;
    for (int k = 0; k < 3; k++) begin
      cycle();
      i_req = 1'b1; i_addr = 32'h100 + 32'(4 * k);
      @(negedge clk);
      checks++; if (i_gnt !== 1'b1 || m_addr !== i_addr || m_we !== 4'b0000) begin failures++;
        $display("FAIL fetch_gnt[%0d]: got gnt=%b addr=%h we=%b expected 1 %h 0000", k, i_gnt, m_addr, m_we, i_addr); end
      if (k > 0) begin
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== exp_data[k-1]) begin failures++;
          $display("FAIL fetch_resp[%0d]: got rvalid=%b data=%h expected 1 %h", k-1, i_rvalid, i_rdata, exp_data[k-1]); end
      end
    end
    cycle();
    i_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== exp_data[2] || d_rvalid !== 1'b0) begin failures++;
      $display("FAIL fetch_resp[2]: got rvalid=%b data=%h d_rvalid=%b expected 1 %h 0", i_rvalid, i_rdata, d_rvalid, exp_data[2]); end
  endtask

  task automatic test_contention();
    cycle();
    d_req = 1'b1; d_addr = 32'h200; d_we = 4'b0000;
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    checks++; if ({d_gnt, i_gnt} !== 2'b10 || m_addr !== 32'h200) begin failures++;
      $display("FAIL contention_gnt: got d_gnt=%b i_gnt=%b addr=%h expected 1 0 200", d_gnt, i_gnt, m_addr); end
    cycle();
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0080 || i_rvalid !== 1'b0) begin failures++;
      $display("FAIL contention_dresp: got d_rvalid=%b data=%h i_rvalid=%b expected 1 a0000080 0", d_rvalid, d_rdata, i_rvalid); end
    checks++; if (i_gnt !== 1'b1 || m_addr !== 32'h10) begin failures++;
      $display("FAIL contention_fetch: got i_gnt=%b addr=%h expected 1 10", i_gnt, m_addr); end
    cycle();
    i_req = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0004) begin failures++;
      $display("FAIL contention_iresp: got i_rvalid=%b data=%h expected 1 a0000004", i_rvalid, i_rdata); end
  endtask

  task automatic test_starvation();
    logic exp_d;
    cycle();
    for (int c = 0; c < 6; c++) begin
      cycle();
      d_req = 1'b1; d_addr = 32'h0; d_we = 4'b0000;
      i_req = 1'b1; i_addr = 32'h4;
      @(negedge clk);
      exp_d = (c != 4);
      checks++; if (d_gnt !== exp_d || i_gnt !== !exp_d) begin failures++;
        $display("FAIL starve_cycle%0d: got d_gnt=%b i_gnt=%b expected %b %b", c, d_gnt, i_gnt, exp_d, !exp_d); end
    end
    cycle();
    d_req = 1'b0; i_req = 1'b0;
    cycle();
  endtask

  task automatic test_store();
    cycle();
    d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; i_req = 1'b0;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1 || m_we !== 4'b0011 || m_wdata !== 32'hDEAD_BEEF || m_addr !== 32'h40) begin failures++;
      $display("FAIL store_drive: got gnt=%b we=%b wdata=%h addr=%h expected 1 0011 deadbeef 40", d_gnt, m_we, m_wdata, m_addr); end
    cycle();
    d_req = 1'b0; d_we = 4'b0000; d_wdata = 32'h0;
    @(negedge clk);
    checks++; if (m_we !== 4'b0000 || m_req !== 1'b0 || d_rvalid !== 1'b0) begin failures++;
      $display("FAIL store_after: got we=%b m_req=%b d_rvalid=%b expected 0000 0 0", m_we, m_req, d_rvalid); end
    cycle();
    d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    checks++; if (d_gnt !== 1'b1) begin failures++;
      $display("FAIL store_readback_gnt: got %b expected 1", d_gnt); end
    cycle();
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_BEEF) begin failures++;
      $display("FAIL store_readback: got rvalid=%b data=%h expected 1 a000beef", d_rvalid, d_rdata); end
  endtask

  task automatic test_reset_midflight();
    cycle();
    reset3 = 1'b0;
    cycle();
    i_req3 = 1'b1; i_addr3 = 32'h8;
    @(negedge clk);
    checks++; if (i_gnt3 !== 1'b1) begin failures++;
      $display("FAIL lat3_gnt: got %b expected 1", i_gnt3); end
    cycle();
    i_req3 = 1'b0;
    @(negedge clk);
    checks++; if (i_rvalid3 !== 1'b0) begin failures++;
      $display("FAIL lat3_early1: got %b expected 0", i_rvalid3); end
    cycle();
    @(negedge clk);
    checks++; if (i_rvalid3 !== 1'b0) begin failures++;
      $display("FAIL lat3_early2: got %b expected 0", i_rvalid3); end
    cycle();
    @(negedge clk);
    checks++; if (i_rvalid3 !== 1'b1) begin failures++;
      $display("FAIL lat3_resp: got %b expected 1", i_rvalid3); end
    cycle();
    i_req3 = 1'b1; i_addr3 = 32'hC;
    @(negedge clk);
    checks++; if (i_gnt3 !== 1'b1) begin failures++;
      $display("FAIL midflight_gnt: got %b expected 1", i_gnt3); end
    cycle();
    i_req3 = 1'b0; reset3 = 1'b1;
    @(negedge clk);
    checks++; if (i_rvalid3 !== 1'b0) begin failures++;
      $display("FAIL midflight_in_reset: got %b expected 0", i_rvalid3); end
    cycle();
    reset3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (i_rvalid3 !== 1'b0) begin failures++;
        $display("FAIL midflight_drop%0d: got %b expected 0", c, i_rvalid3); end
      cycle();
    end
  endtask

  initial begin
    reset = 1'b1; reset3 = 1'b1;
    i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 4'h0;
    i_req3 = 1'b0; i_addr3 = 32'h0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_starvation();
    test_store();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
